fifo_n2w: RTL

Narrow-write, wide-read FIFO that packs pairs of DATA_WIDTH-bit words into 2*DATA_WIDTH-bit words. It is the complement of the team's wide-write, narrow-read register file. It sits between a byte-serial producer, such as a keypad or switch sampler, and a consumer that needs full-width operands. Storage uses a synchronous write port and an asynchronous read port, matching the team's register-file style.

---
 rtl/fifo_n2w_pkg.sv | 8 +
 rtl/fifo_n2w_if.sv | 11 +
 rtl/fifo_n2w_ctrl.sv | 51 +++++
 rtl/fifo_n2w.sv | 37 +++
 4 files changed

// File: rtl/fifo_n2w_pkg.sv
// fifo_n2w_pkg: shared sizing helper for the narrow-write, wide-read FIFO
package fifo_n2w_pkg;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_n2w_if.sv
// fifo_n2w_if: producer/consumer handshake bundle for the narrow-write, wide-read FIFO
interface fifo_n2w_if #(parameter int DATA_WIDTH = 8);
    logic                    wr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    rd;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    empty;
    logic                    full;
    modport master (output wr, w_data, rd, input r_data, empty, full);
    modport slave  (input wr, w_data, rd, output r_data, empty, full);
endinterface

// File: rtl/fifo_n2w_ctrl.sv
// fifo_n2w_ctrl: pointers, occupancy count, acceptance rules and status flags
module fifo_n2w_ctrl
    import fifo_n2w_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [ADDR_WIDTH-1:0] r_addr_o,
    output logic                  we_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] N_C = CW'(depth(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_acc, wr_acc;

    // Flags from count; a full FIFO still takes a write when a read frees a pair
    always_comb begin
        empty_o  = count_q < CW'(2);
        full_o   = count_q == N_C;
        rd_acc   = rd_i & ~empty_o;
        wr_acc   = wr_i & (~full_o | rd_acc);
        we_o     = wr_acc;
        w_addr_o = w_ptr_q;
        r_addr_o = r_ptr_q;
        w_ptr_d  = wr_acc ? w_ptr_q + ADDR_WIDTH'(1) : w_ptr_q;
        r_ptr_d  = rd_acc ? r_ptr_q + ADDR_WIDTH'(2) : r_ptr_q;
        count_d  = CW'((CW + 1)'(count_q) + (CW + 1)'(wr_acc) - (CW + 1)'({rd_acc, 1'b0}));
    end

    // Reset discards everything buffered, including an unpaired half word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_n2w.sv
// fifo_n2w: packs pairs of narrow writes into show-ahead wide reads
module fifo_n2w
    import fifo_n2w_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input logic       clk,
    input logic       reset_n,
    fifo_n2w_if.slave bus
);
    localparam int N = depth(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] w_addr, r_addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] mem_q [N];

    fifo_n2w_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_i     (bus.wr),
        .rd_i     (bus.rd),
        .w_addr_o (w_addr),
        .r_addr_o (r_addr),
        .we_o     (we),
        .empty_o  (bus.empty),
        .full_o   (bus.full)
    );

    // Storage keeps its contents across reset; only the pointers are cleared
    always_ff @(posedge clk) begin
        if (we) mem_q[w_addr] <= bus.w_data;
    end

    assign bus.r_data = {mem_q[r_addr], mem_q[r_addr + ADDR_WIDTH'(1)]};

endmodule
